calc_bcd_display: RTL

CALC_BCD_DISPLAY -- requirements
Module: calc_bcd_display

---
 rtl/calc_pkg.sv | 43 ++++
 rtl/seg7_decode.sv | 28 ++
 rtl/calc_bcd_display.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator / BCD display block.
// Holds the active-low 7-segment patterns {g,f,e,d,c,b,a}, the operation
// and converter-state enumerations, and a small constant helper.
package calc_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Five BCD digits cover the largest result (16 bits -> 65535).
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MUL  = 2'd2,
    OP_PASS = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  function automatic int unsigned pow10(input int n);
    int unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Ports: bcd  - 4-bit BCD digit
//        seg  - 7-bit active-low segments; non-decimal codes show blank
module seg7_decode
  import calc_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_bcd_display.sv
// Push-button calculator with signed-magnitude decimal 7-segment display.
// Two unsigned operands on SW are added, subtracted, multiplied or passed
// through on a KEY press; the result is converted to BCD by a sequential
// double-dabble FSM and latched onto the display when conversion completes.
// Ports:
//   CLOCK_50 - clock, all state on rising edge
//   RESET    - synchronous, active-high
//   SW       - operands A = SW[2*OPW-1:OPW], B = SW[OPW-1:0]
//   KEY      - active-low buttons: 0 add, 1 sub, 2 mul, 3 pass-through
//   LEDR     - {sign, busy, magnitude[7:0]}
//   HEX      - DIGITS active-low 7-segment digits, digit 0 least significant
module calc_bcd_display
  import calc_pkg::*;
#(
  parameter int OPW    = 5,
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic [2*OPW-1:0]      SW,
  input  logic [3:0]            KEY,
  output logic [9:0]            LEDR,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int          RW    = 2 * OPW;
  localparam int          LW    = (RW < 8) ? RW : 8;
  localparam int unsigned LIMIT = pow10(DIGITS - 1);

  if (OPW < 2 || OPW > 8) begin : g_bad_opw
    $error("calc_bcd_display: OPW must be in 2..8");
  end
  if (DIGITS < 2 || DIGITS > 6) begin : g_bad_digits
    $error("calc_bcd_display: DIGITS must be in 2..6");
  end

  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Button synchronisers and falling-edge detector. Everything clears to 0
  // ("held down"), so a button must be seen released before it can fire;
  // a button held through reset release therefore never produces a press.
  logic [3:0] key_s1, key_s2, key_prev, press;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_s1   <= '0;
      key_s2   <= '0;
      key_prev <= '0;
      press    <= '0;
    end else begin
      key_s1   <= KEY;
      key_s2   <= key_s1;
      key_prev <= key_s2;
      press    <= key_prev & ~key_s2;
    end
  end

  // Operation select (lowest KEY index wins) and result computation
  logic [OPW-1:0] opa, opb;
  logic           any_press;
  op_e            op;
  logic [RW-1:0]  res;
  logic           res_neg;

  assign opa       = SW[2*OPW-1:OPW];
  assign opb       = SW[OPW-1:0];
  assign any_press = |press;

  always_comb begin
    op = OP_PASS;
    if      (press[0]) op = OP_ADD;
    else if (press[1]) op = OP_SUB;
    else if (press[2]) op = OP_MUL;
  end

  always_comb begin
    res     = '0;
    res_neg = 1'b0;
    case (op)
      OP_ADD: res = RW'(opa) + RW'(opb);
      OP_SUB: begin
        if (opa >= opb) begin
          res = RW'(opa - opb);
        end else begin
          res     = RW'(opb - opa);
          res_neg = 1'b1;
        end
      end
      OP_MUL:  res = RW'(opa) * RW'(opb);
      OP_PASS: res = SW;
      default: res = '0;
    endcase
  end

  // Converter FSM
  conv_state_e state, state_n;
  logic [4:0]  cnt;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_press) state_n = SHIFT;
      SHIFT:   if (cnt == 5'(RW - 1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Magnitude / double-dabble datapath. sh is a working copy of the
  // magnitude so mag stays intact for the overflow test at DONE.
  logic [RW-1:0]    mag, sh;
  logic             neg;
  logic [BCD_W-1:0] bcd, bcd_adj;

  assign bcd_adj = dd_adjust(bcd);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      mag <= '0;
      sh  <= '0;
      neg <= 1'b0;
      bcd <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_press) begin
            mag <= res;
            sh  <= res;
            neg <= res_neg;
            bcd <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          bcd <= {bcd_adj[BCD_W-2:0], sh[RW-1]};
          sh  <= sh << 1;
          cnt <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Display formatting
  logic [6:0]          dec [DIGITS-1];
  logic                ovf;
  logic [7*DIGITS-1:0] hex_n;
  logic                seen;

  for (genvar k = 0; k < DIGITS - 1; k++) begin : g_dig
    seg7_decode u_dec (
      .bcd (bcd[4*k +: 4]),
      .seg (dec[k])
    );
  end

  assign ovf = ({{(32 - RW){1'b0}}, mag} >= LIMIT);

  always_comb begin
    hex_n = '0;
    seen  = 1'b0;
    for (int k = DIGITS - 2; k >= 0; k--) begin
      if (bcd[4*k +: 4] != 4'd0) seen = 1'b1;
      if (ovf)                   hex_n[7*k +: 7] = SEG_MINUS;
      else if (seen || k == 0)   hex_n[7*k +: 7] = dec[k];
      else                       hex_n[7*k +: 7] = SEG_BLANK;
    end
    hex_n[7*(DIGITS-1) +: 7] = (ovf || neg) ? SEG_MINUS : SEG_BLANK;
  end

  // Display registers, updated only on DONE so an aborted run shows nothing
  logic [7*DIGITS-1:0] hex_r;
  logic [7:0]          led_r;
  logic                sign_r;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      for (int k = 0; k < DIGITS; k++) begin
        hex_r[7*k +: 7] <= (k == 0) ? SEG_0 : SEG_BLANK;
      end
      led_r  <= '0;
      sign_r <= 1'b0;
    end else if (state == DONE) begin
      hex_r  <= hex_n;
      led_r  <= 8'(mag[LW-1:0]);
      sign_r <= neg;
    end
  end

  assign HEX  = hex_r;
  assign LEDR = {sign_r, (state != IDLE), led_r};

endmodule
